// File: rtl/meter_timer.sv
// Parking-meter remaining-time counter.
// Holds the remaining seconds as one binary count and registers its BCD
// digits together with the low-time and expired indications.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (count -> 0)
//   tick_1hz     one-second enable pulse; decrements a nonzero count
//   add60/180/300 debounced add pulses; only the largest one is applied
//   load15/150   force the count to 15 / 150 (load150 has priority)
//   digit3..0    BCD thousands..units of the remaining seconds
//   state_blink  remaining < LOW_SEC
//   expired      remaining == 0
module meter_timer #(
   parameter int unsigned MAX_SEC = 9999,
   parameter int unsigned LOW_SEC = 180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       add60,
   input  logic       add180,
   input  logic       add300,
   input  logic       load15,
   input  logic       load150,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       state_blink,
   output logic       expired
);

   localparam int unsigned CNT_W = 14;   // holds any four-digit BCD value
   localparam int unsigned SUM_W = 15;   // headroom for MAX_SEC + 300
   localparam int unsigned ADD_W = 9;
   localparam int unsigned BCD_W = 16;

   // Encoding chosen so the two indication outputs are state bits directly:
   // bit 1 = state_blink, bit 0 = expired.
   typedef enum logic [1:0] {
      NORMAL  = 2'b00,
      LOW     = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   state_t             state_q, state_nxt;
   logic [CNT_W-1:0]   count_q, count_nxt;
   logic [BCD_W-1:0]   bcd_q, bcd_nxt;
   logic [ADD_W-1:0]   add_amt;
   logic [SUM_W-1:0]   sum;

   // Combinational double-dabble binary-to-BCD conversion.
   function automatic logic [BCD_W-1:0] to_bcd(input logic [CNT_W-1:0] bin);
      logic [BCD_W-1:0] bcd;
      bcd = '0;
      for (int i = CNT_W - 1; i >= 0; i--) begin
         for (int d = 0; d < 4; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5)
               bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
         end
         bcd = {bcd[BCD_W-2:0], bin[i]};
      end
      return bcd;
   endfunction

   // State, count and digit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EXPIRED;
         count_q <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_nxt;
         count_q <= count_nxt;
         bcd_q   <= bcd_nxt;
      end
   end

   // Next count, next digits and next state; state follows the next count only.
   always_comb begin
      add_amt   = '0;
      sum       = '0;
      count_nxt = count_q;
      state_nxt = state_q;

      if (add300)
         add_amt = ADD_W'(300);
      else if (add180)
         add_amt = ADD_W'(180);
      else if (add60)
         add_amt = ADD_W'(60);

      // Decrement before saturation; the count > 0 guard prevents underflow.
      sum = SUM_W'(count_q)
          - SUM_W'((tick_1hz && (count_q != '0)) ? 1 : 0)
          + SUM_W'(add_amt);

      if (load150)
         count_nxt = CNT_W'(150);
      else if (load15)
         count_nxt = CNT_W'(15);
      else if (sum > SUM_W'(MAX_SEC))
         count_nxt = CNT_W'(MAX_SEC);
      else
         count_nxt = CNT_W'(sum);

      if (count_nxt == '0)
         state_nxt = EXPIRED;
      else if (count_nxt < CNT_W'(LOW_SEC))
         state_nxt = LOW;
      else
         state_nxt = NORMAL;

      bcd_nxt = to_bcd(count_nxt);
   end

   assign digit3      = bcd_q[15:12];
   assign digit2      = bcd_q[11:8];
   assign digit1      = bcd_q[7:4];
   assign digit0      = bcd_q[3:0];
   assign state_blink = state_q[1];
   assign expired     = state_q[0];

endmodule

// File: tb/tb_meter_timer.sv
// Randomized and directed bench for meter_timer against a decimal-arithmetic model.
module tb_meter_timer;

   logic       clk = 1'b0;
   logic       rst, tick_1hz, add60, add180, add300, load15, load150;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       state_blink, expired;

   int checks   = 0;
   int failures = 0;
   int model_cnt = 0;

   meter_timer dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1hz   (tick_1hz),
      .add60      (add60),
      .add180     (add180),
      .add300     (add300),
      .load15     (load15),
      .load150    (load150),
      .digit3     (digit3),
      .digit2     (digit2),
      .digit1     (digit1),
      .digit0     (digit0),
      .state_blink(state_blink),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] dec_digits(input int c);
      return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   function automatic logic [15:0] shown();
      return {digit3, digit2, digit1, digit0};
   endfunction

   // One clock with the given inputs; model update and full output compare.
   task automatic step(input logic r, input logic t, input logic a60, input logic a180,
                       input logic a300, input logic l15, input logic l150);
      int a;
      @(negedge clk);
      rst = r; tick_1hz = t; add60 = a60; add180 = a180; add300 = a300;
      load15 = l15; load150 = l150;
      @(posedge clk);
      #1;
      if (r) model_cnt = 0;
      else if (l150) model_cnt = 150;
      else if (l15) model_cnt = 15;
      else begin
         a = a300 ? 300 : a180 ? 180 : a60 ? 60 : 0;
         model_cnt = model_cnt - ((t && model_cnt > 0) ? 1 : 0) + a;
         if (model_cnt > 9999) model_cnt = 9999;
      end
      check("digits",  32'(shown()), 32'(dec_digits(model_cnt)));
      check("blink",   32'(state_blink), 32'(model_cnt < 180));
      check("expired", 32'(expired), 32'(model_cnt == 0));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; tick_1hz = 0; add60 = 0; add180 = 0; add300 = 0; load15 = 0; load150 = 0;

      // Reset then tick at zero stays at zero.
      step(1, 0, 0, 0, 0, 0, 0);
      check("rst_digits", 32'(shown()), 32'h0000);
      check("rst_exp",    32'(expired), 32'd1);
      check("rst_blink",  32'(state_blink), 32'd1);
      ticks(1);
      check("tick0", 32'(shown()), 32'h0000);

      // load150, three ticks, then add60.
      step(0, 0, 0, 0, 0, 0, 1);
      ticks(3);
      check("l150_3t", 32'(shown()), 32'h0147);
      check("l150_blink", 32'(state_blink), 32'd1);
      check("l150_exp", 32'(expired), 32'd0);
      step(0, 0, 1, 0, 0, 0, 0);
      check("add60", 32'(shown()), 32'h0207);
      check("add60_blink", 32'(state_blink), 32'd0);

      // Count 100, add60 with tick.
      step(0, 0, 0, 0, 0, 0, 1);
      ticks(50);
      check("c100", 32'(shown()), 32'h0100);
      step(0, 1, 1, 0, 0, 0, 0);
      check("add_tick", 32'(shown()), 32'h0159);

      // Saturation at 9999.
      for (int i = 0; i < 34; i++) step(0, 0, 0, 0, 1, 0, 0);
      ticks(49);
      check("c9950", 32'(shown()), 32'h9950);
      step(0, 0, 0, 0, 1, 0, 0);
      check("sat300", 32'(shown()), 32'h9999);
      step(0, 0, 1, 0, 0, 0, 0);
      check("sat60", 32'(shown()), 32'h9999);
      ticks(1);
      check("sat_tick", 32'(shown()), 32'h9998);

      // LOW threshold crossing and expiry.
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0);
      ticks(30);
      check("c180", 32'(shown()), 32'h0180);
      check("c180_blink", 32'(state_blink), 32'd0);
      ticks(1);
      check("c179", 32'(shown()), 32'h0179);
      check("c179_blink", 32'(state_blink), 32'd1);
      step(0, 0, 0, 0, 0, 1, 0);
      ticks(14);
      check("c1", 32'(shown()), 32'h0001);
      ticks(1);
      check("c0", 32'(shown()), 32'h0000);
      check("c0_exp", 32'(expired), 32'd1);

      // Priority cases.
      step(0, 0, 0, 0, 1, 1, 0);
      check("l15_add", 32'(shown()), 32'h0015);
      step(0, 0, 1, 0, 1, 0, 0);
      check("multi_add", 32'(shown()), 32'h0315);
      step(1, 0, 0, 0, 0, 0, 1);
      check("rst_l150", 32'(shown()), 32'h0000);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 1, 1, 1, 1, 1, 1);
      check("rst_all", 32'(shown()), 32'h0000);
      ticks(1);
      check("rst_tick", 32'(shown()), 32'h0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 6,
              $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/meter_timer.md
METER_TIMER -- requirements
Module: meter_timer

Interface
REQ-001 SHALL have parameter MAX_SEC, default 9999, meaning the saturation ceiling in seconds, which must fit in four BCD digits.
REQ-002 SHALL have parameter LOW_SEC, default 180, meaning the threshold below which the low-time indication is asserted.
REQ-003 SHALL have port clk, input, width 1: the single system clock, with all logic on the rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port tick_1hz, input, width 1: a one-clk-wide enable pulse, once per second, from the clock divider.
REQ-006 SHALL have port add60, input, width 1: a one-clk-wide debounced pulse that adds 60 s.
REQ-007 SHALL have port add180, input, width 1: a one-clk-wide debounced pulse that adds 180 s.
REQ-008 SHALL have port add300, input, width 1: a one-clk-wide debounced pulse that adds 300 s.
REQ-009 SHALL have port load15, input, width 1: a one-clk-wide pulse that forces the remaining time to 15 s.
REQ-010 SHALL have port load150, input, width 1: a one-clk-wide pulse that forces the remaining time to 150 s.
REQ-011 SHALL have port digit3, output, width 4: the BCD thousands digit of the remaining seconds.
REQ-012 SHALL have port digit2, output, width 4: the BCD hundreds digit.
REQ-013 SHALL have port digit1, output, width 4: the BCD tens digit.
REQ-014 SHALL have port digit0, output, width 4: the BCD units digit.
REQ-015 SHALL have port state_blink, output, width 1: asserted while remaining < LOW_SEC, consumed by the display controller.
REQ-016 SHALL have port expired, output, width 1: asserted while remaining == 0.

Function
REQ-017 SHALL hold the remaining time as a single registered count in the range 0..MAX_SEC; the digits SHALL always equal its BCD encoding, with each digit in 0..9.
REQ-018 SHALL update the count once per clk according to this priority: rst, then load150, then load15, then add/tick.
REQ-019 SHALL, on load150 or load15, set the count to exactly 150 or 15 respectively; an add or tick in the same cycle SHALL be ignored.
REQ-020 SHALL select an add amount A per cycle: 300 if add300, else 180 if add180, else 60 if add60, else 0; only one add SHALL be applied per cycle.
REQ-021 SHALL define the decrement D as 1 when tick_1hz is high and count > 0, else 0.
REQ-022 SHALL set the next count to min(count - D + A, MAX_SEC); the decrement SHALL be applied before saturation.
REQ-023 SHALL NOT decrement below 0; a tick with count == 0 SHALL leave the count at 0.
REQ-024 SHALL register all outputs, with digits, state_blink and expired reflecting the new count exactly 1 clk after the triggering edge.
REQ-025 SHALL derive state_blink = (count < LOW_SEC) and expired = (count == 0) from the registered count, with no extra lag relative to the digits.
REQ-026 SHALL treat an input held high for N cycles as N pulses; it SHALL NOT perform its own edge detection.
REQ-027 SHALL update the digits with a carry/borrow-correct BCD adder/subtractor or an equivalent binary-to-BCD path, meeting timing in one clk with no multicycle stall.
REQ-028 SHALL run its operating modes as a state machine with states EXPIRED (count == 0), LOW (0 < count < LOW_SEC) and NORMAL (count >= LOW_SEC).
REQ-029 SHALL make every state transition solely as a function of the next count; no separate state register may disagree with the count.

Reset
REQ-030 SHALL, when rst is high at a clk edge, set the count to 0, the digits to 0/0/0/0, expired=1 and state_blink=1, regardless of any other input.
REQ-031 SHALL, on a reset asserted mid-countdown, discard the current count; the first post-reset tick SHALL keep 0000.
REQ-032 SHALL ignore all other inputs in any cycle where rst is high.

Verification
REQ-033 SHALL be verified with: rst -> digits 0000, expired=1, state_blink=1; then a tick -> still 0000.
REQ-034 SHALL be verified with: load150, then 3 ticks -> 0147, state_blink=1, expired=0; then add60 -> 0207, state_blink=0.
REQ-035 SHALL be verified with: count 100, add60 and tick in the same clk -> 0159 one clk later.
REQ-036 SHALL be verified with: count 9950, add300 -> 9999; then add60 -> 9999; then tick -> 9998.
REQ-037 SHALL be verified with: count 0180, tick -> 0179 with state_blink rising on the same cycle as the digits; count 0001, tick -> 0000, expired=1.
REQ-038 SHALL be verified with: load15 and add300 in the same clk -> 0015; add60 and add300 together -> +300 only; rst asserted alongside load150 -> 0000.
